// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter
// between NUM_REQ byte requesters, with guard gap.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 8,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 uart_tx_data,
  output logic                       uart_tx_start,
  input  logic                       uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout_err,
  output logic [CNT_W-1:0]           frames_sent,
  output logic [CNT_W-1:0]           frames_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WW  = $clog2(BUSY_TIMEOUT);
  localparam int GW  = (GAP_CYCLES > 1) ?
                       $clog2(GAP_CYCLES) : 1;

  localparam logic [IDW-1:0] PTR_RST =
    IDW'(NUM_REQ - 1);
  localparam logic [WW-1:0] W_LAST =
    WW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE =
    NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               active_q, active_d;
  logic               terr_q, terr_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic               found;
  logic [IDW-1:0]     sel;
  logic [7:0]         sel_byte;

  function automatic int slot(
    input logic [IDW-1:0] p,
    input int             k
  );
    return (int'(p) + k) % NUM_REQ;
  endfunction

  // Pick first valid requester after the last winner
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_byte = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid[slot(ptr_q, i)]) begin
        found    = 1'b1;
        sel      = IDW'(slot(ptr_q, i));
        sel_byte = req_data[slot(ptr_q, i)*8 +: 8];
      end
    end
  end

  // Frame sequencing: next state and registered outputs
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    ready_d  = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    id_d     = id_q;
    active_d = active_q;
    terr_d   = 1'b0;
    sent_d   = sent_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          ready_d  = ONE << sel;
          data_d   = sel_byte;
          id_d     = sel;
          active_d = 1'b1;
          ptr_d    = sel;
          state_d  = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wcnt_q == W_LAST) begin
          terr_d  = 1'b1;
          err_d   = err_q + 1'b1;
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          sent_d  = sent_q + 1'b1;
          gcnt_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt_q == G_LAST) begin
          active_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_RST;
      wcnt_q   <= '0;
      gcnt_q   <= '0;
      ready_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
      active_q <= 1'b0;
      terr_q   <= 1'b0;
      sent_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      gcnt_q   <= gcnt_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      data_q   <= data_d;
      id_q     <= id_d;
      active_q <= active_d;
      terr_q   <= terr_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
    end
  end

  assign req_ready     = ready_q;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = start_q;
  assign grant_id      = id_q;
  assign grant_active  = active_q;
  assign timeout_err   = terr_q;
  assign frames_sent   = sent_q;
  assign frames_err    = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: timeline model,
// per-cycle compare, directed scenarios.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int G   = 16;
  localparam int BT  = 8;
  localparam int CW  = 16;
  localparam int GL  = (G == 0) ? 1 : G;
  localparam int LEN = 40;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_busy;
  logic [1:0]    grant_id;
  logic          grant_active;
  logic          timeout_err;
  logic [CW-1:0] frames_sent;
  logic [CW-1:0] frames_err;

  uart_tx_scheduler #(
    .NUM_REQ(N),
    .GAP_CYCLES(G),
    .BUSY_TIMEOUT(BT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_tx_data(uart_tx_data),
    .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy),
    .grant_id(grant_id),
    .grant_active(grant_active),
    .timeout_err(timeout_err),
    .frames_sent(frames_sent),
    .frames_err(frames_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int rq_cyc[$];
  int rq_id[$];
  int st_cyc[$];
  logic [7:0] st_data[$];
  int to_cyc[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle after
  // start and stays high LEN cycles
  bit never_busy = 1'b0;
  int bcnt = 0;
  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        bcnt = 0;
        uart_tx_busy <= 1'b0;
      end else begin
        if (uart_tx_start && !never_busy) bcnt = LEN;
        if (bcnt > 0) begin
          uart_tx_busy <= 1'b1;
          bcnt--;
        end else begin
          uart_tx_busy <= 1'b0;
        end
      end
    end
  end

  // Scheduler model: timestamps of frame events
  bit       m_frame;
  bit       m_rose;
  int       m_g;
  int       m_rise;
  int       m_free_at;
  int       m_last;
  int       m_sent;
  int       m_err;
  logic [N-1:0]  e_ready;
  logic          e_start;
  logic [7:0]    e_data;
  logic [1:0]    e_id;
  logic          e_active;
  logic          e_terr;
  logic [CW-1:0] e_sent;
  logic [CW-1:0] e_err;

  task automatic m_reset();
    m_frame   = 1'b0;
    m_rose    = 1'b0;
    m_g       = 0;
    m_rise    = 0;
    m_free_at = 0;
    m_last    = N - 1;
    m_sent    = 0;
    m_err     = 0;
    e_ready   = '0;
    e_start   = 1'b0;
    e_data    = '0;
    e_id      = '0;
    e_active  = 1'b0;
    e_terr    = 1'b0;
    e_sent    = '0;
    e_err     = '0;
  endtask

  task automatic end_frame(input int c);
    m_frame   = 1'b0;
    m_free_at = c + 1 + GL;
  endtask

  task automatic m_step();
    int c;
    int sel;
    int k;
    c       = cyc;
    e_ready = '0;
    e_start = 1'b0;
    e_terr  = 1'b0;
    if (!m_frame && c >= m_free_at &&
        enable && req_valid != '0) begin
      sel = -1;
      for (int i = 1; i <= N; i++) begin
        k = (m_last + i) % N;
        if (sel < 0 && req_valid[k]) sel = k;
      end
      m_frame  = 1'b1;
      m_rose   = 1'b0;
      m_g      = c;
      m_last   = sel;
      e_ready  = N'(1) << sel;
      e_data   = req_data[8*sel +: 8];
      e_id     = 2'(sel);
      e_active = 1'b1;
    end else if (m_frame && c >= m_g + 2) begin
      if (!m_rose) begin
        if (uart_tx_busy) begin
          m_rose = 1'b1;
          m_rise = c;
        end else if (c == m_g + 1 + BT) begin
          e_terr = 1'b1;
          m_err++;
          end_frame(c);
        end
      end else if (c > m_rise && !uart_tx_busy) begin
        m_sent++;
        end_frame(c);
      end
    end
    if (m_frame && c == m_g + 1) e_start = 1'b1;
    if (!m_frame && c + 1 >= m_free_at) e_active = 1'b0;
    e_sent = CW'(m_sent);
    e_err  = CW'(m_err);
    cyc++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Compare process plus event log
  initial begin
    forever begin
      @(negedge clk);
      if (|req_ready) begin
        rq_cyc.push_back(cyc);
        for (int i = 0; i < N; i++)
          if (req_ready[i]) rq_id.push_back(i);
      end
      if (uart_tx_start) begin
        st_cyc.push_back(cyc);
        st_data.push_back(uart_tx_data);
      end
      if (timeout_err) to_cyc.push_back(cyc);
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("tx_start", 64'(uart_tx_start), 64'(e_start));
      chk("tx_data", 64'(uart_tx_data), 64'(e_data));
      chk("grant_id", 64'(grant_id), 64'(e_id));
      chk("grant_active", 64'(grant_active),
          64'(e_active));
      chk("timeout_err", 64'(timeout_err), 64'(e_terr));
      chk("frames_sent", 64'(frames_sent), 64'(e_sent));
      chk("frames_err", 64'(frames_err), 64'(e_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    rq_cyc.delete();
    rq_id.delete();
    st_cyc.delete();
    st_data.delete();
    to_cyc.delete();
  endtask

  task automatic do_reset();
    tick(1);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic wait_grants(input int k,
                             input int lim);
    int i;
    i = 0;
    while (rq_cyc.size() < k && i < lim) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (rq_cyc.size() < k) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_grants got=%0d want=%0d",
               rq_cyc.size(), k);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 0);
    chk({tag, "_start"}, 64'(uart_tx_start), 0);
    chk({tag, "_data"}, 64'(uart_tx_data), 0);
    chk({tag, "_id"}, 64'(grant_id), 0);
    chk({tag, "_active"}, 64'(grant_active), 0);
    chk({tag, "_terr"}, 64'(timeout_err), 0);
    chk({tag, "_sent"}, 64'(frames_sent), 0);
    chk({tag, "_err"}, 64'(frames_err), 0);
  endtask

  int r;
  logic [7:0] exp_d[5];

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tick(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    clear_log();

    // Single requester, byte 0x55
    req_data  = 32'h0000_0055;
    req_valid = 4'b0001;
    enable    = 1'b1;
    wait_grants(1, 20);
    tick(1);
    req_valid = '0;
    r = (rq_cyc.size() > 0) ? rq_cyc[0] : cyc;
    chk("t1_id", 64'(rq_id.size() > 0 ? rq_id[0] : 9), 0);
    goto(r + 2);
    chk("t1_start_cyc",
        64'(st_cyc.size() > 0 ? st_cyc[0] : 0), 64'(r + 1));
    chk("t1_start_data",
        64'(st_data.size() > 0 ? st_data[0] : 8'h0), 8'h55);
    goto(r + 42);
    chk("t1_sent_before", 64'(frames_sent), 0);
    goto(r + 43);
    chk("t1_sent_after", 64'(frames_sent), 1);
    goto(r + 58);
    chk("t1_active_gap", 64'(grant_active), 1);
    goto(r + 59);
    chk("t1_active_off", 64'(grant_active), 0);
    chk("t1_ngrants", 64'(rq_cyc.size()), 1);

    // All four valid: strict rotation
    do_reset();
    req_data  = 32'hA3A2_A1A0;
    req_valid = 4'b1111;
    wait_grants(5, 400);
    tick(1);
    req_valid = '0;
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    for (int i = 0; i < 5 && i < rq_id.size(); i++)
      chk("t2_id", 64'(rq_id[i]), 64'(i % N));
    for (int i = 0; i < 5 && i < st_data.size(); i++)
      chk("t2_data", 64'(st_data[i]), 64'(exp_d[i]));
    for (int i = 0; i < 4 && i + 1 < rq_cyc.size(); i++)
      chk("t2_spacing",
          64'(rq_cyc[i+1] - rq_cyc[i]), 60);
    tick(80);

    // Requesters 1 and 3 only, pointer at 1
    do_reset();
    req_data  = 32'h3300_1100;
    req_valid = 4'b0010;
    wait_grants(1, 20);
    tick(1);
    req_valid = 4'b1010;
    wait_grants(3, 200);
    tick(1);
    req_valid = '0;
    chk("t3_n", 64'(rq_id.size()), 3);
    if (rq_id.size() >= 3) begin
      chk("t3_id0", 64'(rq_id[0]), 1);
      chk("t3_id1", 64'(rq_id[1]), 3);
      chk("t3_id2", 64'(rq_id[2]), 1);
      chk("t3_sp1", 64'(rq_cyc[1] - rq_cyc[0]), 60);
      chk("t3_sp2", 64'(rq_cyc[2] - rq_cyc[1]), 60);
      chk("t3_data", 64'(st_data[1]), 8'h33);
    end
    tick(80);

    // Transmitter never goes busy
    do_reset();
    never_busy = 1'b1;
    req_data   = 32'h0000_2211;
    req_valid  = 4'b0011;
    wait_grants(2, 60);
    tick(1);
    req_valid = '0;
    chk("t4_nto", 64'(to_cyc.size()), 1);
    if (to_cyc.size() > 0 && st_cyc.size() > 0 &&
        rq_cyc.size() > 1) begin
      chk("t4_to_delay", 64'(to_cyc[0] - st_cyc[0]), 8);
      chk("t4_next_id", 64'(rq_id[1]), 1);
      chk("t4_next_cyc", 64'(rq_cyc[1] - to_cyc[0]), 17);
    end
    chk("t4_err", 64'(frames_err), 1);
    chk("t4_sent", 64'(frames_sent), 0);
    tick(40);
    never_busy = 1'b0;
    tick(2);

    // Reset in the middle of a frame
    do_reset();
    req_data  = 32'hA3A2_A1A0;
    req_valid = 4'b1111;
    wait_grants(1, 20);
    tick(15);
    chk("t5_busy_pre", 64'(uart_tx_busy), 1);
    rst = 1'b1;
    #1;
    chk_outs_zero("t5_async");
    tick(3);
    rst = 1'b0;
    clear_log();
    wait_grants(1, 20);
    chk("t5_first_id",
        64'(rq_id.size() > 0 ? rq_id[0] : 9), 0);
    tick(1);
    req_valid = '0;
    tick(70);

    // enable low blocks grants; drop mid-frame
    enable = 1'b0;
    do_reset();
    req_valid = 4'b1111;
    tick(100);
    chk("t6_no_grant", 64'(rq_cyc.size()), 0);
    enable = 1'b1;
    wait_grants(1, 20);
    tick(10);
    enable = 1'b0;
    tick(120);
    chk("t6_sent", 64'(frames_sent), 1);
    chk("t6_ngrants", 64'(rq_cyc.size()), 1);
    chk("t6_active", 64'(grant_active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte requesters.
- Accepts one byte per grant over a valid/ready handshake and drives the transmitter's tx_data/tx_start pair.
- Tracks the transmitter's tx_busy to sequence frames and inserts a programmable inter-frame guard gap.
- Sits between the system-side byte producers and the UART host's transmit port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles inserted after each frame before the next grant (0 allowed).
- BUSY_TIMEOUT, 8, cycles to wait for tx_busy to rise after tx_start before declaring an error (>=2).
- CNT_W, 16, width of the sent/error frame counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  when 0, no new grants; an in-flight frame completes normally.
- req_valid  input  NUM_REQ  per-requester byte available; held until the matching req_ready.
- req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot, single-cycle accept pulse; data is sampled this cycle.
- uart_tx_data  output  8  byte to transmitter; stable from START until the next grant.
- uart_tx_start  output  1  single-cycle start pulse to transmitter.
- uart_tx_busy  input  1  transmitter busy flag.
- grant_id  output  clog2(NUM_REQ)  index of current/last granted requester.
- grant_active  output  1  high from grant until the end of GAP.
- timeout_err  output  1  single-cycle pulse when tx_busy fails to rise.
- frames_sent  output  CNT_W  count of completed frames, wraps.
- frames_err  output  CNT_W  count of timeouts, wraps.

Behaviour:
- Reset values: all outputs 0.
  - Internal RR pointer resets to NUM_REQ-1, so requester 0 has first priority.
  - State resets to IDLE; all counters reset to 0.
- All outputs are registered.
- Reset mid-frame aborts the sequence immediately; there is no pending start after reset.
- IDLE:
  - When enable=1 and any req_valid=1, select the first valid index searching upward from pointer+1, modulo NUM_REQ.
  - In that cycle: assert req_ready[sel]=1, latch req_data[sel] into uart_tx_data, set grant_id=sel, set grant_active=1, set pointer=sel.
  - Next state: START.
- START:
  - uart_tx_start=1 for exactly this cycle; clear the wait counter.
  - Next state: WAIT_BUSY.
- WAIT_BUSY:
  - If uart_tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the wait counter. When it reaches BUSY_TIMEOUT: pulse timeout_err, increment frames_err, go to GAP.
- WAIT_DONE:
  - When uart_tx_busy=0, increment frames_sent and go to GAP.
  - There is no timeout in this state; the transmitter's own reset clears busy.
- GAP:
  - Count GAP_CYCLES cycles, then clear grant_active and go to IDLE.
  - GAP_CYCLES=0 means GAP lasts exactly 1 cycle.
- Fairness: a requester that was just granted has lowest priority at the next arbitration, even if it re-asserts valid immediately.
- Requesters with no valid are skipped with no cycle penalty.
- req_valid deasserted before ready: no grant is issued to that requester and nothing is latched.
- enable falling during WAIT_BUSY/WAIT_DONE/GAP: the current frame completes and the scheduler returns to IDLE without a new grant.
- Busy already high in START (transmitter still busy from a foreign source): WAIT_BUSY exits on the first cycle, and WAIT_DONE waits for that busy to fall.
  - This is accepted behaviour; the frame may be lost and is still counted.
- Minimum grant-to-grant spacing = 1 (IDLE) + 1 (START) + ≥1 (WAIT_BUSY) + frame length + GAP + 1.
- Counter wrap: frames_sent/frames_err roll over from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Single requester: req_valid=4'b0001, data 0x55; busy model rises 1 cycle after start and lasts 40 cycles.
  - Required: req_ready[0] pulses once.
  - Next cycle: uart_tx_start=1 with uart_tx_data=0x55.
  - frames_sent=1 after busy falls; grant_active low after 16 GAP cycles.
- All four valid continuously with data 0xA0..0xA3.
  - Required: grant order 0,1,2,3,0.
  - Each grant is spaced ≥ 40+16+4 cycles apart; the uart_tx_data sequence is A0,A1,A2,A3,A0.
- Requesters 1 and 3 valid, pointer at 1 (after a grant to 1).
  - Required: next grant is 3, then 1; requesters 0 and 2 are skipped with no extra cycles.
- Busy model never asserts; BUSY_TIMEOUT=8.
  - Required: timeout_err pulses exactly 8 cycles after START exits, frames_err=1, frames_sent=0.
  - The scheduler returns to IDLE and grants the next requester.
- Reset asserted during WAIT_DONE.
  - Required: all outputs are 0 immediately (asynchronously) and the state is IDLE.
  - After release, requester 0 wins the first arbitration among all-valid.
- enable=0 with req_valid=4'b1111.
  - Required: no req_ready for 100 cycles.
  - Dropping enable mid-frame still lets that frame finish with frames_sent incremented, and no further grant follows.
